// File: rtl/ctrl_pipe_reg_if.sv
// Control-bundle pipeline bus: upstream word/valid, per-stage stall/flush,
// and the per-stage contents exposed downstream.
//   ctrl_in/valid_in : control word and its valid from decode
//   stall/flush      : per-stage hold and kill requests (bit i = stage i)
//   in_ready         : stage 0 accepts ctrl_in this cycle
//   ctrl_out         : stage i occupies bits [i*WIDTH +: WIDTH]
//   valid_out        : valid bit of each stage
interface ctrl_pipe_reg_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 3
);
    logic [WIDTH-1:0]        ctrl_in;
    logic                    valid_in;
    logic [STAGES-1:0]       stall;
    logic [STAGES-1:0]       flush;
    logic                    in_ready;
    logic [STAGES*WIDTH-1:0] ctrl_out;
    logic [STAGES-1:0]       valid_out;

    modport master (
        output ctrl_in, valid_in, stall, flush,
        input  in_ready, ctrl_out, valid_out
    );

    modport slave (
        input  ctrl_in, valid_in, stall, flush,
        output in_ready, ctrl_out, valid_out
    );
endinterface

// File: rtl/ctrl_pipe_reg.sv
// Multi-stage pipeline register for a control word with per-stage valid,
// stall (propagating upstream) and flush, bubble insertion below a stalled
// stage, and a saturating bubble counter at the last stage.
//   clk, reset : clock and synchronous active-high reset
//   bus        : control pipeline bus (slave side)
//   cnt_clr    : clears the bubble counter
//   bubble_cnt : saturating count of cycles with the last stage invalid
module ctrl_pipe_reg #(
    parameter int unsigned             WIDTH     = 16,
    parameter int unsigned             STAGES    = 3,
    parameter logic [WIDTH-1:0]        RESET_VAL = '0,
    parameter int unsigned             CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    ctrl_pipe_reg_if.slave   bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_src_valid;
    logic [WIDTH-1:0]  w_src_ctrl [STAGES];

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_ctrl [STAGES];
    logic [CNT_W-1:0]  r_bubble_cnt;

    // Effective hold: a stage holds if it or any stage below it stalls
    always_comb begin
        w_hold = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            w_hold[i] = |(bus.stall >> i);
        end
    end

    assign bus.in_ready = ~w_hold[0];

    // Load source per stage; an upstream stage held by its own stall
    // presents an invalid entry so the advancing stage takes a bubble
    for (genvar gi = 0; gi < int'(STAGES); gi++) begin : g_src
        if (gi == 0) begin : g_first
            assign w_src_valid[gi] = bus.valid_in;
            assign w_src_ctrl[gi]  = bus.ctrl_in;
        end else begin : g_next
            assign w_src_valid[gi] = r_valid[gi-1] & ~w_hold[gi-1];
            assign w_src_ctrl[gi]  = r_ctrl[gi-1];
        end
        assign bus.ctrl_out[gi*WIDTH +: WIDTH] = r_ctrl[gi];
    end

    // Stage registers: reset > flush > hold > load (invalid loads gated)
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(STAGES); i++) begin
            if (reset || bus.flush[i]) begin
                r_valid[i] <= 1'b0;
                r_ctrl[i]  <= RESET_VAL;
            end else if (!w_hold[i]) begin
                r_valid[i] <= w_src_valid[i];
                r_ctrl[i]  <= w_src_valid[i] ? w_src_ctrl[i] : RESET_VAL;
            end
        end
    end

    assign bus.valid_out = r_valid;

    // Saturating bubble counter on the last stage
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            r_bubble_cnt <= '0;
        end else if (!r_valid[STAGES-1] && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign bubble_cnt = r_bubble_cnt;

endmodule
